// File: rtl/instr_encoder.sv
// RV32 R/I-type instruction encoder feeding a DEPTH-word output FIFO (latency 1, no bypass).
// Optional MUL encoding is enabled by defining INSTR_ENCODER_MUL_EN; otherwise op 2 is illegal.
module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_op,
   input  logic [4:0]               in_rd,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   input  logic [11:0]              in_imm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_code,
   output logic                     illegal,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_illegal;

   logic          w_legal, w_rtype, w_acc, w_push, w_pop;
   logic [2:0]    w_f3;
   logic [6:0]    w_f7;
   logic [31:0]   w_code;

   always_comb begin
      w_legal = 1'b1;
      w_rtype = 1'b1;
      w_f3    = 3'b000;
      w_f7    = 7'b0000000;
      case (in_op)
         4'd0:  ;
         4'd1:  w_f7 = 7'b0100000;
`ifdef INSTR_ENCODER_MUL_EN
         4'd2:  w_f7 = 7'b0000001;
`endif
         4'd3:  w_f3 = 3'b111;
         4'd4:  w_f3 = 3'b110;
         4'd5:  w_f3 = 3'b100;
         4'd6:  w_f3 = 3'b010;
         4'd7:  w_f3 = 3'b011;
         4'd8:  w_f3 = 3'b001;
         4'd9:  w_f3 = 3'b101;
         4'd10: begin w_f3 = 3'b101; w_f7 = 7'b0100000; end
         4'd11: w_rtype = 1'b0;
         4'd12: begin w_rtype = 1'b0; w_f3 = 3'b111; end
         4'd13: begin w_rtype = 1'b0; w_f3 = 3'b110; end
         4'd14: begin w_rtype = 1'b0; w_f3 = 3'b100; end
         default: w_legal = 1'b0;
      endcase
      w_code = w_rtype ? {w_f7, in_rs2, in_rs1, w_f3, in_rd, 7'b0110011}
                       : {in_imm, in_rs1, w_f3, in_rd, 7'b0010011};
   end

   // rst_n gating holds in_ready low for the whole reset assertion
   assign in_ready  = rst_n & (r_count < DEPTH_C);
   assign out_valid = (r_count != '0);
   assign out_code  = out_valid ? r_mem[r_rptr] : 32'h0;
   assign illegal   = r_illegal;
   assign count     = r_count;

   assign w_acc  = in_valid & in_ready;
   assign w_push = w_acc & w_legal;
   assign w_pop  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_acc & ~w_legal;
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (default build: MUL illegal), queue-based reference model.
module tb_instr_encoder;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, illegal;
   logic [3:0]  in_op;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [11:0] in_imm;
   logic [31:0] out_code;
   logic [$clog2(DEPTH):0] count;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] q[$];
   logic        exp_ill;

   int F3 [0:14] = '{0, 0, 0, 7, 6, 4, 2, 3, 1, 5, 5, 0, 7, 6, 4};

   instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .illegal(illegal), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input int op);
      return (op < 15) && (op != 2);
   endfunction

   function automatic logic [31:0] model_enc(input int op, rd, rs1, rs2, imm);
      int f7;
      f7 = (op == 1 || op == 10) ? 32 : (op == 2 ? 1 : 0);
      if (op <= 10) return 32'((f7 << 25) + (rs2 << 20) + (rs1 << 15) + (F3[op] << 12) + (rd << 7) + 51);
      else          return 32'((imm << 20) + (rs1 << 15) + (F3[op] << 12) + (rd << 7) + 19);
   endfunction

   task automatic drv(input bit v, input int op, rd, rs1, rs2, imm, input bit ordy);
      in_valid = v; in_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
      in_rs2 = 5'(rs2); in_imm = 12'(imm); out_ready = ordy;
   endtask

   // advance one clock, update the model from the pre-edge inputs, then compare
   task automatic cycle();
      bit acc, pop;
      int op;
      op  = int'(in_op);
      acc = in_valid && (q.size() < DEPTH);
      pop = (q.size() != 0) && out_ready;
      @(posedge clk); #1;
      if (pop) void'(q.pop_front());
      if (acc && legal(op))
         q.push_back(model_enc(op, int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm)));
      exp_ill = acc && !legal(op);
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("illegal", 32'(illegal), 32'(exp_ill));
      if (q.size() != 0) chk("out_code", out_code, q[0]);
   endtask

   initial begin
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_out_code", out_code, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rel_in_ready", 32'(in_ready), 1);

      // ADD: word visible one cycle after accept
      drv(1, 0, 3, 1, 2, 0, 1);
      chk("add_pre_valid", 32'(out_valid), 0);
      cycle();
      chk("add_code", out_code, 32'h002081B3);
      chk("add_valid", 32'(out_valid), 1);
      drv(0, 0, 0, 0, 0, 0, 1);
      cycle();

      // SUB then ADDI, drained in order
      drv(1, 1, 5, 6, 7, 0, 0);        cycle();
      drv(1, 11, 1, 0, 31, 12'hFFF, 0); cycle();
      drv(0, 0, 0, 0, 0, 0, 0);        cycle();
      chk("sub_code", out_code, 32'h407302B3);
      out_ready = 1'b1;                cycle();
      chk("addi_code", out_code, 32'hFFF00093);
      cycle();
      chk("drained", 32'(out_valid), 0);

      // MUL is illegal in the default build
      drv(1, 2, 3, 1, 2, 0, 1); cycle();
      chk("mul_illegal", 32'(illegal), 1);
      chk("mul_count", 32'(count), 0);
      drv(0, 0, 0, 0, 0, 0, 1); cycle();
      chk("mul_pulse_end", 32'(illegal), 0);

      // fill: DEPTH+1 back-to-back ADDs with out_ready low
      for (int i = 1; i <= 5; i++) begin
         drv(1, 0, i, 1, 2, 0, 0);
         while (!in_ready || int'(count) < i - 1) cycle();
         cycle();
         if (i == 4) begin
            chk("full_count", 32'(count), 4);
            chk("full_ready", 32'(in_ready), 0);
         end
         if (i == 4) break;
      end
      drv(1, 0, 5, 1, 2, 0, 0); cycle();
      chk("full_hold", 32'(count), 4);
      out_ready = 1'b1; cycle();
      chk("pop1_ready", 32'(in_ready), 1);
      chk("pop1_rd", 32'(out_code[11:7]), 2);
      chk("pop1_count", 32'(count), 3);
      cycle();
      drv(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) cycle();
      chk("fill_drained", 32'(count), 0);

      // op 15 held while full: no pulse until space exists
      for (int i = 0; i < 4; i++) begin drv(1, 0, 9, 1, 2, 0, 0); cycle(); end
      drv(1, 15, 0, 0, 0, 0, 0); cycle(); cycle();
      chk("op15_full_noill", 32'(illegal), 0);
      out_ready = 1'b1; cycle();
      chk("op15_pop_noill", 32'(illegal), 0);
      out_ready = 1'b0; cycle();
      chk("op15_ill", 32'(illegal), 1);
      chk("op15_count", 32'(count), 3);
      in_valid = 1'b0; cycle();

      // reset between edges with three words held
      rst_n = 1'b0; #1;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_code", out_code, 32'h0);
      q.delete();
      @(negedge clk); rst_n = 1'b1;
      drv(1, 0, 3, 1, 2, 0, 1); cycle();
      chk("post_rst_code", out_code, 32'h002081B3);
      drv(0, 0, 0, 0, 0, 0, 1); cycle();
      chk("post_rst_empty", 32'(out_valid), 0);

      // randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         drv($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4095),
             $urandom_range(0, 2) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning output FIFO depth in words (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  request carries a valid operation.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port in_op  input  4  operation select: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 ADDI, 12 ANDI, 13 ORI, 14 XORI, 15 reserved.
REQ-007 The block SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 The block SHALL have port in_imm  input  12  I-type immediate.
REQ-009 The block SHALL have port out_valid  output  1  out_code holds an encoded word.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the word this cycle.
REQ-011 The block SHALL have port out_code  output  32  encoded RV32 instruction word.
REQ-012 The block SHALL have port illegal  output  1  one-cycle pulse: an accepted request was not encodable.
REQ-013 The block SHALL have port count  output  clog2(DEPTH)+1  number of words held.

Function
REQ-014 Accept SHALL occur on a rising edge with in_valid and in_ready both high; in_ready SHALL equal (count < DEPTH), derived from registered state only.
REQ-015 R-type ops (0-10) SHALL encode {funct7, rs2, rs1, funct3, rd, 7'b0110011}; funct3: ADD/SUB/MUL 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111; funct7: SUB/SRA 0100000, MUL 0000001, others 0000000.
REQ-016 I-type ops (11-14) SHALL encode {imm[11:0], rs1, funct3, rd, 7'b0010011}; funct3: ADDI 000, XORI 100, ORI 110, ANDI 111; in_rs2 ignored.
REQ-017 An accepted legal request SHALL be written to the FIFO tail on the accept edge; out_valid SHALL rise no earlier than the following cycle (latency 1, no bypass).
REQ-018 An accepted op 15 (or MUL when excluded, REQ-027) SHALL be consumed, not enqueued, and SHALL pulse illegal high for exactly the next cycle.
REQ-019 out_valid SHALL equal (count != 0); out_code SHALL show the FIFO head and SHALL stay stable while out_valid && !out_ready.
REQ-020 Pop SHALL occur on a rising edge with out_valid and out_ready high; head pointer advances, wrapping modulo DEPTH.
REQ-021 Simultaneous legal push and pop SHALL leave count unchanged and preserve order.
REQ-022 Full: in_ready low, no push; a pop in that cycle SHALL raise in_ready next cycle, not the same cycle.
REQ-023 Empty: out_valid low; out_ready ignored; count never underflows or exceeds DEPTH.
REQ-024 Words SHALL leave in exact acceptance order; illegal requests SHALL not disturb order or count.

Reset
REQ-025 With rst_n low, immediately and independent of clk: count 0, pointers 0, out_valid 0, illegal 0, out_code 32'h0, in_ready 0 only while rst_n low, then 1.
REQ-026 Reset mid-operation SHALL discard all buffered words; no partial word SHALL appear after release.

Configuration
REQ-027 Macro INSTR_ENCODER_MUL_EN: defined -> op 2 encodes MUL (funct7 0000001); undefined -> op 2 treated as illegal per REQ-018 and no MUL decode logic present.

Verification
REQ-028 ADD rd=3 rs1=1 rs2=2, out_ready=1 -> out_code 32'h002081B3 with out_valid one cycle after accept.
REQ-029 SUB rd=5 rs1=6 rs2=7 -> 32'h407302B3; ADDI rd=1 rs1=0 imm=12'hFFF -> 32'hFFF00093, in that order.
REQ-030 MUL rd=3 rs1=1 rs2=2: with INSTR_ENCODER_MUL_EN -> 32'h022081B3; without -> illegal pulses 1 cycle, count stays 0.
REQ-031 out_ready=0, push DEPTH+1 back-to-back ADDs with rd=1..5 -> in_ready low after 4th, count=4; release out_ready -> rd 1..4 emerge in order, 5th accepted only after first pop.
REQ-032 Full FIFO plus op 15 held on in_valid -> not accepted, no illegal pulse until space exists; then one pulse, count unchanged.
REQ-033 count=3, assert rst_n low between clock edges -> out_valid and count 0 immediately; after release first new ADD is the only word output.
